// File: rtl/immed_gen_pipe.sv
// immed_gen_pipe: RISC-V immediate decode with PC-relative target, buffered in a small valid/ready FIFO
module immed_gen_pipe #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_instr,
  input  logic [XLEN-1:0]               in_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_imm,
  output logic [2:0]                    out_fmt,
  output logic [XLEN-1:0]               out_target,
  output logic [$clog2(FIFO_DEPTH):0]   out_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [6:0]      op;
  logic [2:0]      fmt;
  logic [XLEN-1:0] imm, tgt;
  logic [XLEN-1:0] imm_q [FIFO_DEPTH];
  logic [XLEN-1:0] tgt_q [FIFO_DEPTH];
  logic [2:0]      fmt_q [FIFO_DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  logic            rdy_q, push, pop;
  // decode format, immediate and target from the incoming instruction
  always_comb begin
    op  = in_instr[6:0];
    fmt = (op == 7'h03 || op == 7'h13 || op == 7'h1B || op == 7'h67 || op == 7'h73) ? 3'd1 :
          (op == 7'h23) ? 3'd2 :
          (op == 7'h63) ? 3'd3 :
          (op == 7'h37 || op == 7'h17) ? 3'd4 :
          (op == 7'h6F) ? 3'd5 : 3'd0;
    imm = (fmt == 3'd1) ? {{(XLEN-11){in_instr[31]}}, in_instr[30:20]} :
          (fmt == 3'd2) ? {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]} :
          (fmt == 3'd3) ? {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
          (fmt == 3'd4) ? {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0} :
          (fmt == 3'd5) ? {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
          '0;
    tgt = (fmt == 3'd3 || fmt == 3'd5 || op == 7'h17) ? in_pc + imm : '0;
  end
  assign in_ready  = rdy_q && (cnt < CW'(FIFO_DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_count = cnt;
  assign out_imm    = out_valid ? imm_q[rp] : '0;
  assign out_fmt    = out_valid ? fmt_q[rp] : '0;
  assign out_target = out_valid ? tgt_q[rp] : '0;
  // queue pointers and occupancy; reset beats flush, flush beats push/pop
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (flush) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + AW'(1);
        if (pop) rp <= rp + AW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
  // entry storage needs no reset since occupancy gates every read
  always_ff @(posedge CLK) begin
    if (!RST && !flush && push) begin
      imm_q[wp] <= imm;
      fmt_q[wp] <= fmt;
      tgt_q[wp] <= tgt;
    end
  end
endmodule

// File: tb/tb_immed_gen_pipe.sv
// tb_immed_gen_pipe: randomized and directed checks of two immed_gen_pipe configurations against a queue model
module tb_immed_gen_pipe;
  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
  } ent_t;
  logic        clk = 0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        ir32, ov32, ir64, ov64;
  logic [31:0] imm32, tgt32;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt32, fmt64;
  logic [1:0]  cnt32;
  logic [2:0]  cnt64;
  int          checks = 0;
  int          failures = 0;
  ent_t        q32[$];
  ent_t        q64[$];
  logic        rdy32 = 0, rdy64 = 0, held = 0;
  logic [6:0]  ops [13] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h00};
  logic        r, f, v, o;
  logic [31:0] ins;
  logic [63:0] p;
  immed_gen_pipe #(.XLEN(32), .FIFO_DEPTH(2)) dut32 (
    .CLK(clk), .RST(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .in_instr(instr), .in_pc(pc[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_target(tgt32), .out_count(cnt32)
  );
  immed_gen_pipe #(.XLEN(64), .FIFO_DEPTH(4)) dut64 (
    .CLK(clk), .RST(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .in_instr(instr), .in_pc(pc), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_target(tgt64), .out_count(cnt64)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic ent_t calc(input logic [31:0] i, input logic [63:0] pcv, input int xl);
    ent_t e;
    logic signed [11:0] vi = i[31:20];
    logic signed [11:0] vs = {i[31:25], i[11:7]};
    logic signed [12:0] vb = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    logic signed [31:0] vu = {i[31:12], 12'b0};
    logic signed [20:0] vj = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    logic [63:0] mask = (xl == 32) ? 64'hFFFF_FFFF : '1;
    e.fmt = 0;
    e.imm = 0;
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin e.fmt = 1; e.imm = 64'(vi); end
      7'h23: begin e.fmt = 2; e.imm = 64'(vs); end
      7'h63: begin e.fmt = 3; e.imm = 64'(vb); end
      7'h37, 7'h17: begin e.fmt = 4; e.imm = 64'(vu); end
      7'h6F: begin e.fmt = 5; e.imm = 64'(vj); end
      default: ;
    endcase
    e.imm = e.imm & mask;
    e.tgt = (e.fmt == 3 || e.fmt == 5 || i[6:0] == 7'h17) ? ((pcv + e.imm) & mask) : 0;
    return e;
  endfunction
  task automatic check_all();
    ent_t h32, h64;
    h32 = '{imm: 0, fmt: 0, tgt: 0};
    h64 = '{imm: 0, fmt: 0, tgt: 0};
    if (q32.size() != 0) h32 = q32[0];
    if (q64.size() != 0) h64 = q64[0];
    chk("ready32", 64'(ir32), 64'(rdy32 && q32.size() < 2));
    chk("count32", 64'(cnt32), 64'(q32.size()));
    chk("valid32", 64'(ov32), 64'(q32.size() != 0));
    chk("imm32", 64'(imm32), h32.imm);
    chk("fmt32", 64'(fmt32), 64'(h32.fmt));
    chk("tgt32", 64'(tgt32), h32.tgt);
    chk("ready64", 64'(ir64), 64'(rdy64 && q64.size() < 4));
    chk("count64", 64'(cnt64), 64'(q64.size()));
    chk("valid64", 64'(ov64), 64'(q64.size() != 0));
    chk("imm64", imm64, h64.imm);
    chk("fmt64", 64'(fmt64), 64'(h64.fmt));
    chk("tgt64", tgt64, h64.tgt);
  endtask
  task automatic step(input logic sr, input logic sf, input logic sv, input logic [31:0] si,
                      input logic [63:0] sp, input logic so);
    logic a32, a64, p32, p64;
    rst = sr; flush = sf; in_valid = sv; instr = si; pc = sp; out_ready = so;
    a32 = sv && rdy32 && q32.size() < 2;
    a64 = sv && rdy64 && q64.size() < 4;
    p32 = so && q32.size() != 0;
    p64 = so && q64.size() != 0;
    if (sr) begin
      q32.delete(); q64.delete(); rdy32 = 0; rdy64 = 0;
    end else begin
      rdy32 = 1; rdy64 = 1;
      if (sf) begin
        q32.delete(); q64.delete();
      end else begin
        if (p32) void'(q32.pop_front());
        if (p64) void'(q64.pop_front());
        if (a32) q32.push_back(calc(si, sp, 32));
        if (a64) q64.push_back(calc(si, sp, 64));
      end
    end
    held = sv && !sr && !sf && !(a32 && a64);
    @(negedge clk);
    check_all();
  endtask
  task automatic direct(input logic [31:0] di, input logic [63:0] dp, input logic w64,
                        input logic [2:0] ef, input logic [63:0] ei, input logic [63:0] et);
    step(0, 0, 1, di, dp, 0);
    chk("dir_valid", 64'(w64 ? ov64 : ov32), 64'd1);
    chk("dir_fmt", 64'(w64 ? fmt64 : fmt32), 64'(ef));
    chk("dir_imm", w64 ? imm64 : 64'(imm32), ei);
    chk("dir_tgt", w64 ? tgt64 : 64'(tgt32), et);
    step(0, 0, 0, di, dp, 1);
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 32'hFFF00093, 0, 0);
    chk("rst_ready", 64'(ir32), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_ready", 64'(ir32), 64'd1);
    direct(32'hFFF00093, 64'h0,   0, 3'd1, 64'hFFFF_FFFF, 64'h0);
    direct(32'hFE000EE3, 64'h100, 0, 3'd3, 64'hFFFF_FFFC, 64'hFC);
    direct(32'h0080006F, 64'h200, 0, 3'd5, 64'h8, 64'h208);
    direct(32'hFE20AC23, 64'h0,   0, 3'd2, 64'hFFFF_FFF8, 64'h0);
    direct(32'h800002B7, 64'h40,  1, 3'd4, 64'hFFFF_FFFF_8000_0000, 64'h0);
    direct(32'h002081B3, 64'h40,  1, 3'd0, 64'h0, 64'h0);
    step(0, 0, 1, 32'h00100093, 64'h10, 0);
    step(0, 0, 1, 32'h00200093, 64'h14, 0);
    step(0, 0, 1, 32'h00300093, 64'h18, 0);
    chk("full_ready", 64'(ir32), 64'd0);
    chk("full_count", 64'(cnt32), 64'd2);
    chk("full_head", 64'(imm32), 64'd1);
    step(0, 0, 1, 32'h00300093, 64'h18, 1);
    chk("order_2nd", 64'(imm32), 64'd2);
    step(0, 0, 1, 32'h00300093, 64'h18, 1);
    chk("order_3rd", 64'(imm32), 64'd3);
    for (int n = 0; n < 6; n++) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h00500093, 64'h20, 0);
    step(0, 0, 1, 32'h00600093, 64'h24, 0);
    step(0, 1, 1, 32'h00700093, 64'h28, 1);
    chk("flush_count", 64'(cnt32), 64'd0);
    chk("flush_valid", 64'(ov32), 64'd0);
    chk("flush_ready", 64'(ir32), 64'd1);
    step(0, 0, 1, 32'h00500093, 64'h20, 0);
    step(0, 0, 1, 32'h00600093, 64'h24, 0);
    step(1, 0, 1, 32'h00700093, 64'h28, 1);
    chk("rst_count", 64'(cnt32), 64'd0);
    chk("rst_valid", 64'(ov32), 64'd0);
    chk("rst_mid_ready", 64'(ir32), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    held = 0;
    for (int n = 0; n < 800; n++) begin
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 24) == 0);
      o = ($urandom_range(0, 2) != 0);
      if (held) v = 1;
      else begin
        v = ($urandom_range(0, 3) != 0);
        ins = $urandom;
        if ($urandom_range(0, 5) != 0) ins[6:0] = ops[$urandom_range(0, 12)];
        p = {$urandom, $urandom};
      end
      step(r, f, v, ins, p, o);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
